mca_frame_rx: RTL and testbench

Receive-side frame decoder for the MCA spectrum link. It consumes the byte stream from a UART receiver and hunts for the 6-byte ASCII start sequence "launch". It then assembles the following 2×N_WORDS bytes, high byte first, into 16-bit words and writes each one into a spectrum RAM at consecutive addresses. It sits between the UART RX core and the host-side (or loopback-test) spectrum buffer, mirroring the MCA transmit FSM.

---
 rtl/mca_frame_rx_if.sv | 24 ++
 rtl/mca_frame_rx.sv | 160 ++++++++++++++++
 tb/tb_mca_frame_rx.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mca_frame_rx_if.sv
// Byte-stream input and spectrum-RAM write port of the MCA frame receiver.
// The slave modport is the decoder side; the master modport drives the byte stream.
interface mca_frame_rx_if #(
    parameter int ADDR_W = 10
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_wdata;
    logic              busy;
    logic              frame_done;
    logic              frame_error;

    modport master (
        output rx_valid, rx_data,
        input  ram_we, ram_addr, ram_wdata, busy, frame_done, frame_error
    );

    modport slave (
        input  rx_valid, rx_data,
        output ram_we, ram_addr, ram_wdata, busy, frame_done, frame_error
    );
endinterface

// File: rtl/mca_frame_rx.sv
// Hunts the "launch" start sequence in a UART byte stream, then writes the following
// N_WORDS high-byte-first 16-bit words to consecutive spectrum-RAM addresses.
module mca_frame_rx #(
    parameter int N_WORDS        = 1024,
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic          clk,
    input  logic          rst,
    mca_frame_rx_if.slave bus
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        HUNT,
        DATA_HI,
        DATA_LO
    } state_t;

    state_t            r_state;
    logic [2:0]        r_hdr_idx;
    logic [ADDR_W-1:0] r_word_idx;
    logic [7:0]        r_hi;
    logic [TO_W-1:0]   r_timeout;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [15:0]       r_ram_wdata;
    logic              r_busy;
    logic              r_frame_done;
    logic              r_frame_error;

    state_t            w_state;
    logic [2:0]        w_hdr_idx;
    logic [ADDR_W-1:0] w_word_idx;
    logic [7:0]        w_hi;
    logic [TO_W-1:0]   w_timeout;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [15:0]       w_ram_wdata;
    logic              w_busy;
    logic              w_frame_done;
    logic              w_frame_error;
    logic [7:0]        w_expected;
    logic              w_timeout_hit;

    always_comb begin
        case (r_hdr_idx)
            3'd0:    w_expected = 8'h6c;  // l
            3'd1:    w_expected = 8'h61;  // a
            3'd2:    w_expected = 8'h75;  // u
            3'd3:    w_expected = 8'h6e;  // n
            3'd4:    w_expected = 8'h63;  // c
            default: w_expected = 8'h68;  // h
        endcase
    end

    // An incoming byte always beats a simultaneous timeout expiry.
    assign w_timeout_hit = r_busy && (r_timeout == TO_W'(TIMEOUT_CYCLES));

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        w_state       = r_state;
        w_hdr_idx     = r_hdr_idx;
        w_word_idx    = r_word_idx;
        w_hi          = r_hi;
        w_ram_we      = 1'b0;
        w_ram_addr    = r_ram_addr;
        w_ram_wdata   = r_ram_wdata;
        w_frame_done  = 1'b0;
        w_frame_error = 1'b0;

        if (bus.rx_valid || !r_busy || w_timeout_hit) begin
            w_timeout = '0;
        end else begin
            w_timeout = r_timeout + 1'b1;
        end

        if (bus.rx_valid) begin
            case (r_state)
                HUNT: begin
                    if (bus.rx_data == w_expected) begin
                        if (r_hdr_idx == 3'd5) begin
                            w_hdr_idx  = 3'd0;
                            w_word_idx = '0;
                            w_state    = DATA_HI;
                        end else begin
                            w_hdr_idx = r_hdr_idx + 3'd1;
                        end
                    end else begin
                        // 'l' is the only byte that can restart the header mid-match.
                        w_hdr_idx = (bus.rx_data == 8'h6c) ? 3'd1 : 3'd0;
                    end
                end
                DATA_HI: begin
                    w_hi    = bus.rx_data;
                    w_state = DATA_LO;
                end
                DATA_LO: begin
                    w_ram_we    = 1'b1;
                    w_ram_addr  = r_word_idx;
                    w_ram_wdata = {r_hi, bus.rx_data};
                    if (r_word_idx == ADDR_W'(N_WORDS - 1)) begin
                        w_frame_done = 1'b1;
                        w_hdr_idx    = 3'd0;
                        w_state      = HUNT;
                    end else begin
                        w_word_idx = r_word_idx + 1'b1;
                        w_state    = DATA_HI;
                    end
                end
                default: begin
                    w_hdr_idx = 3'd0;
                    w_state   = HUNT;
                end
            endcase
        end else if (w_timeout_hit) begin
            w_frame_error = 1'b1;
            w_hdr_idx     = 3'd0;
            w_state       = HUNT;
        end

        w_busy = (w_state != HUNT) || (w_hdr_idx != 3'd0);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            r_state       <= HUNT;
            r_hdr_idx     <= 3'd0;
            r_word_idx    <= '0;
            r_hi          <= 8'h00;
            r_timeout     <= '0;
            r_ram_we      <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_wdata   <= 16'h0000;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_hdr_idx     <= w_hdr_idx;
            r_word_idx    <= w_word_idx;
            r_hi          <= w_hi;
            r_timeout     <= w_timeout;
            r_ram_we      <= w_ram_we;
            r_ram_addr    <= w_ram_addr;
            r_ram_wdata   <= w_ram_wdata;
            r_busy        <= w_busy;
            r_frame_done  <= w_frame_done;
            r_frame_error <= w_frame_error;
        end
    end

    assign bus.ram_we      = r_ram_we;
    assign bus.ram_addr    = r_ram_addr;
    assign bus.ram_wdata   = r_ram_wdata;
    assign bus.busy        = r_busy;
    assign bus.frame_done  = r_frame_done;
    assign bus.frame_error = r_frame_error;
endmodule

// File: tb/tb_mca_frame_rx.sv
// Randomised bench for mca_frame_rx: a string-matching reference model predicts every
// RAM write and timeout abort, and a negedge monitor checks them against the DUT.
module tb_mca_frame_rx;
    localparam int N_WORDS = 64;
    localparam int ADDR_W  = 6;
    localparam int TO      = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mca_frame_rx_if #(.ADDR_W(ADDR_W)) bus ();

    mca_frame_rx #(
        .N_WORDS       (N_WORDS),
        .ADDR_W        (ADDR_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit                is_err;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
        bit                done;
        int                cyc;
    } exp_t;

    exp_t sb[$];

    // Reference model: header found by suffix matching over recent bytes, data as byte pairs.
    logic [7:0] hdr [6] = '{8'h6c, 8'h61, 8'h75, 8'h6e, 8'h63, 8'h68};
    logic [7:0] hist[$];
    bit         m_in_frame = 1'b0;
    bit         m_have_hi  = 1'b0;
    logic [7:0] m_hi;
    int         m_word     = 0;
    int         m_idle     = 0;
    int         last_cyc   = 0;
    int         g_min      = 0;
    int         g_max      = 0;

    function automatic bit suffix_is_prefix(int k);
        if (hist.size() < k) return 1'b0;
        for (int i = 0; i < k; i++)
            if (hist[hist.size() - k + i] != hdr[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit model_busy();
        if (m_in_frame) return 1'b1;
        for (int k = 1; k < 6; k++)
            if (suffix_is_prefix(k)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_abort();
        m_in_frame = 1'b0;
        m_have_hi  = 1'b0;
        hist.delete();
    endtask

    task automatic model_feed(input logic [7:0] b, input int c);
        exp_t e;
        if (m_in_frame) begin
            if (!m_have_hi) begin
                m_hi      = b;
                m_have_hi = 1'b1;
            end else begin
                e.is_err  = 1'b0;
                e.addr    = ADDR_W'(m_word);
                e.data    = {m_hi, b};
                e.done    = (m_word == N_WORDS - 1);
                e.cyc     = c;
                sb.push_back(e);
                m_have_hi = 1'b0;
                m_word++;
                if (e.done) model_abort();
            end
        end else begin
            hist.push_back(b);
            if (hist.size() > 6) void'(hist.pop_front());
            if (suffix_is_prefix(6)) begin
                model_abort();
                m_in_frame = 1'b1;
                m_word     = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        exp_t e;
        if (n > 0 && model_busy() && (m_idle + n > TO)) begin
            e.is_err = 1'b1;
            e.addr   = '0;
            e.data   = '0;
            e.done   = 1'b0;
            e.cyc    = last_cyc + TO + 1;
            sb.push_back(e);
            model_abort();
        end
        m_idle += n;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        last_cyc = cyc;
        m_idle   = 0;
        model_feed(b, cyc);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        check("busy_after_byte", 32'(bus.busy), 32'(model_busy()));
        idle(int'($urandom_range(g_max, g_min)));
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic check_reset_outputs();
        check("rst_ram_we",      32'(bus.ram_we),      32'd0);
        check("rst_ram_addr",    32'(bus.ram_addr),    32'd0);
        check("rst_ram_wdata",   32'(bus.ram_wdata),   32'd0);
        check("rst_busy",        32'(bus.busy),        32'd0);
        check("rst_frame_done",  32'(bus.frame_done),  32'd0);
        check("rst_frame_error", 32'(bus.frame_error), 32'd0);
    endtask

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_abort();
        sb.delete();
        m_idle = 0;
        check_reset_outputs();
    endtask

    // Monitor: every DUT output event must match the oldest predicted event.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst && (bus.ram_we || bus.frame_done || bus.frame_error)) begin
            if (sb.size() == 0) begin
                check("unexpected_output",
                      32'({bus.ram_we, bus.frame_done, bus.frame_error}), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("event_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("frame_error", 32'(bus.frame_error), 32'(mon_e.is_err));
                check("ram_we", 32'(bus.ram_we), 32'(!mon_e.is_err));
                if (!mon_e.is_err) begin
                    check("ram_addr",   32'(bus.ram_addr),   32'(mon_e.addr));
                    check("ram_wdata",  32'(bus.ram_wdata),  32'(mon_e.data));
                    check("frame_done", 32'(bus.frame_done), 32'(mon_e.done));
                end else begin
                    check("frame_done_on_error", 32'(bus.frame_done), 32'd0);
                end
                if (bus.frame_done || bus.frame_error)
                    check("busy_at_frame_end", 32'(bus.busy), 32'd0);
            end
        end
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs();

        // Clean frame, value = index, bytes spaced 10 clk apart.
        g_min = 10; g_max = 10;
        send_str("launch");
        for (int k = 0; k < N_WORDS; k++) send_word(16'(k));

        // Resync through junk and a false start.
        g_min = 0; g_max = 9;
        send_str("xxlalaunch");
        for (int k = 0; k < N_WORDS; k++) send_word(16'hA55A);

        // Data that looks like header bytes must not restart the frame.
        send_str("launch");
        for (int k = 0; k < N_WORDS; k++) send_word(16'h6C61);

        // Timeout after 3 words and a dangling high byte, then a normal frame.
        g_min = 0; g_max = 3;
        send_str("launch");
        for (int k = 0; k < 3; k++) send_word(16'(16'h1000 + k));
        g_min = 0; g_max = 0;
        send_byte(8'h12);
        idle(60);
        check("busy_after_timeout", 32'(bus.busy), 32'd0);
        g_min = 0; g_max = 5;
        send_str("launch");
        for (int k = 0; k < N_WORDS; k++) send_word(16'(k) ^ 16'h1234);

        // Timeout inside a partial header.
        send_str("lau");
        idle(60);
        check("busy_after_hdr_timeout", 32'(bus.busy), 32'd0);

        // Reset mid-frame, then a full frame from address 0.
        g_min = 1; g_max = 4;
        send_str("launch");
        for (int k = 0; k < 30; k++) send_word(16'($urandom));
        do_reset();
        send_str("launch");
        for (int k = 0; k < N_WORDS; k++) send_word(16'(k * 3));

        // Back-to-back frames with rx_valid every cycle.
        g_min = 0; g_max = 0;
        for (int f = 0; f < 2; f++) begin
            send_str("launch");
            for (int k = 0; k < N_WORDS; k++) send_word(16'($urandom));
        end

        // Random junk, random words and random spacing.
        for (int f = 0; f < 4; f++) begin
            g_min = 0; g_max = 3;
            for (int j = 0; j < int'($urandom_range(8, 0)); j++) send_byte(8'($urandom));
            send_str("launch");
            for (int k = 0; k < N_WORDS; k++) send_word(16'($urandom));
        end

        g_min = 0; g_max = 0;
        idle(60);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
